// File: rtl/register_read_pkg.sv
// Frame layout, FSM encoding and frame packing shared by the register-bank read and write paths.
// No logic of its own; both ends import it so they agree on where every frame bit lives.
package register_read_pkg;

    localparam logic [3:0] ADDR_DEFAULT = 4'b0001;
    localparam int         FRAME_W      = 12;

    localparam int START_BIT = 0;
    localparam int ACK_BIT   = 1;
    localparam int DATA_LSB  = 2;
    localparam int DATA_MSB  = 9;
    localparam int NACK_BIT  = 10;
    localparam int STOP_BIT  = 11;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_LOAD  = 3'd2;
    localparam state_t ST_SHIFT = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // An empty slot is sent as nack with a zero payload, whatever the bank data says.
    function automatic logic [FRAME_W-1:0] pack_frame(input logic [7:0] data, input logic filled);
        logic [FRAME_W-1:0] f;
        f                    = '0;
        f[START_BIT]         = 1'b1;
        f[STOP_BIT]          = 1'b1;
        f[ACK_BIT]           = filled;
        f[NACK_BIT]          = ~filled;
        f[DATA_MSB:DATA_LSB] = filled ? data : 8'h00;
        return f;
    endfunction

endpackage

// File: rtl/register_read_if.sv
// Request, bank read port and serial output bundle of the register read path.
// The master side issues requests and models the bank; the slave side is register_read.
interface register_read_if;
    logic [3:0]  addreg;
    logic        rd_req;
    logic [2:0]  rd_sel;
    logic [2:0]  reg_sel;
    logic [7:0]  reg_data;
    logic        reg_valid;
    logic        busy;
    logic [11:0] maindata;
    logic        sdo;
    logic        frame_done;
    logic        err;

    modport master (
        output addreg, rd_req, rd_sel, reg_data, reg_valid,
        input  reg_sel, busy, maindata, sdo, frame_done, err
    );

    modport slave (
        input  addreg, rd_req, rd_sel, reg_data, reg_valid,
        output reg_sel, busy, maindata, sdo, frame_done, err
    );
endinterface

// File: rtl/register_read_frame_shifter.sv
// Parallel-load shift register emitting one frame bit per shift, LSB first; bit 0 visible right after load.
// No backpressure: the owner asserts shift every cycle it wants a bit and watches last.
module register_read_frame_shifter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] frame,
    input  logic         shift,
    output logic         bit_out,
    output logic         last
);
    localparam int CNT_W = $clog2(W);

    logic [W-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last    = (cnt_q == CNT_W'(W - 1));
    assign bit_out = sr_q[0];

    // The counter stops on the last bit so it never wraps past the frame.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = frame;
            cnt_d = '0;
        end else if (shift && !last) begin
            sr_d  = {1'b1, sr_q[W-1:1]};
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/register_read.sv
// Reads one bank slot on an addressed request and shifts it out as a 12-bit frame, LSB first.
// Busy for 15 cycles per frame; requests arriving while busy are dropped, not queued.
module register_read #(
    parameter logic [3:0] ADDR    = register_read_pkg::ADDR_DEFAULT,
    parameter int         NREG    = 6,
    parameter int         FRAME_W = register_read_pkg::FRAME_W
) (
    input  logic            clk,
    input  logic            rst,
    register_read_if.slave  bus
);
    import register_read_pkg::*;

    state_t             state_q, state_d;
    logic [2:0]         reg_sel_q, reg_sel_d;
    logic [FRAME_W-1:0] maindata_q, maindata_d;
    logic               err_q, err_d;
    logic               sh_load, sh_shift, sh_bit, sh_last;
    logic               req_hit, sel_ok;

    assign req_hit = bus.rd_req && (bus.addreg == ADDR);
    assign sel_ok  = int'(bus.rd_sel) < NREG;

    always_comb begin
        state_d    = state_q;
        reg_sel_d  = reg_sel_q;
        maindata_d = maindata_q;
        err_d      = 1'b0;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_hit) begin
                    if (sel_ok) begin
                        state_d   = ST_FETCH;
                        reg_sel_d = bus.rd_sel;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            // Bank read port is registered: data for reg_sel shows up one cycle later.
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                maindata_d = pack_frame(bus.reg_data, bus.reg_valid);
                sh_load    = 1'b1;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                sh_shift = 1'b1;
                if (sh_last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            reg_sel_q  <= '0;
            maindata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_sel_q  <= reg_sel_d;
            maindata_q <= maindata_d;
            err_q      <= err_d;
        end
    end

    register_read_frame_shifter #(.W(FRAME_W)) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (sh_load),
        .frame   (maindata_d),
        .shift   (sh_shift),
        .bit_out (sh_bit),
        .last    (sh_last)
    );

    assign bus.reg_sel    = reg_sel_q;
    assign bus.maindata   = maindata_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.sdo        = (state_q == ST_SHIFT) ? sh_bit : 1'b1;
    assign bus.frame_done = (state_q == ST_DONE);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_register_read.sv
`timescale 1ns/1ps
module tb_register_read;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    register_read_if bus();

    register_read #(.ADDR(4'b0001), .NREG(6), .FRAME_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [11:0] frame;
        logic [2:0]  sel;
    } exp_t;
    exp_t exp_q[$];

    // Bank model with a registered read port.
    logic [7:0] bank_data [8];
    logic       bank_vld  [8];
    always @(posedge clk) begin
        bus.reg_data  <= bank_data[bus.reg_sel];
        bus.reg_valid <= bank_vld[bus.reg_sel];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: observed 0x%0h with nothing expected", name, act);
    endtask

    // Monitor: reconstructs each frame from the serial line and checks it against the scoreboard.
    int          idx = 0;
    logic        prev_busy = 1'b0;
    logic [11:0] sbits = '0;
    bit          aborting = 1'b0;
    exp_t        e;

    always @(negedge clk) begin
        if (bus.busy === 1'b1) begin
            idx = prev_busy ? idx + 1 : 0;
            if (idx == 0 && !aborting) begin
                if (exp_q.size() == 0) flag("unexpected_start", 32'(bus.reg_sel));
                else chk("reg_sel_fetch", 32'(bus.reg_sel), 32'(exp_q[0].sel));
            end
            if (idx >= 2 && idx <= 13) sbits = {bus.sdo, sbits[11:1]};
            else chk("sdo_high_nonshift", 32'(bus.sdo), 32'd1);
            if (bus.frame_done === 1'b1) begin
                chk("frame_done_time", 32'(idx), 32'd14);
                if (exp_q.size() == 0) flag("unexpected_frame", 32'(bus.maindata));
                else begin
                    e = exp_q.pop_front();
                    chk("maindata", 32'(bus.maindata), 32'(e.frame));
                    chk("sdo_serial", 32'(sbits), 32'(e.frame));
                end
            end
        end else begin
            chk("sdo_idle", 32'(bus.sdo), 32'd1);
            if (bus.frame_done !== 1'b0) flag("frame_done_idle", 32'(bus.frame_done));
            if (prev_busy) begin
                if (aborting) aborting = 1'b0;
                else chk("busy_cycles", 32'(idx + 1), 32'd15);
            end
        end
        prev_busy = bus.busy;
    end

    task automatic start_read(input logic [3:0] a, input logic [2:0] s);
        bus.addreg = a;
        bus.rd_sel = s;
        bus.rd_req = 1'b1;
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) flag(name, 32'(n));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.addreg = '0;
        bus.rd_req = 1'b0;
        bus.rd_sel = '0;
        for (int i = 0; i < 8; i++) begin
            bank_data[i] = 8'h00;
            bank_vld[i]  = 1'b0;
        end
        bank_data[0] = 8'hA5; bank_vld[0] = 1'b1;
        bank_data[1] = 8'h3C; bank_vld[1] = 1'b1;
        bank_data[2] = 8'hC3; bank_vld[2] = 1'b1;
        bank_data[3] = 8'h5A; bank_vld[3] = 1'b1;
        bank_data[5] = 8'hFF; bank_vld[5] = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state held while idle: {sdo,busy,err,frame_done,reg_sel,maindata}.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reset_idle", {13'd0, bus.sdo, bus.busy, bus.err, bus.frame_done, bus.reg_sel, bus.maindata},
                {13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000});
        end
        @(posedge clk); #1;

        // Filled slot 0.
        exp_q.push_back('{12'hA97, 3'd0});
        start_read(4'b0001, 3'd0);
        wait_idle("timeout_slot0");
        chk("maindata_hold", 32'(bus.maindata), 32'h0A97);

        // Empty slot 5: nack frame, bank data ignored.
        exp_q.push_back('{12'hC01, 3'd5});
        start_read(4'b0001, 3'd5);
        wait_idle("timeout_slot5");

        // Wrong device address: nothing happens.
        start_read(4'b0010, 3'd0);
        for (int i = 0; i < 5; i++) begin
            chk("wrong_addr_quiet", {29'd0, bus.busy, bus.err, bus.sdo}, {29'd0, 3'b001});
            @(posedge clk); #1;
        end

        // Out-of-range slot: one-cycle err, reg_sel keeps its last value.
        start_read(4'b0001, 3'd6);
        chk("oor_err_high", {28'd0, bus.err, bus.busy, bus.reg_sel}, {28'd0, 1'b1, 1'b0, 3'd5});
        @(posedge clk); #1;
        chk("oor_err_low", {30'd0, bus.err, bus.busy}, {30'd0, 2'b00});

        // Request during SHIFT is dropped: exactly one frame.
        exp_q.push_back('{12'h96B, 3'd3});
        start_read(4'b0001, 3'd3);
        repeat (5) @(posedge clk);
        #1;
        bus.rd_sel = 3'd4;
        bus.rd_req = 1'b1;
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        wait_idle("timeout_slot3");
        repeat (20) @(posedge clk);
        #1;
        chk("no_queued_request", {31'd0, bus.busy}, 32'd0);

        // Reset mid-frame during bit 5.
        aborting = 1'b1;
        start_read(4'b0001, 3'd0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_outputs", {12'd0, bus.sdo, bus.busy, bus.frame_done, bus.err, bus.reg_sel, 1'b0, bus.maindata},
            {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 12'h000});
        repeat (20) @(posedge clk);
        #1;

        // Back-to-back: request held high, second accepted at E16.
        exp_q.push_back('{12'h8F3, 3'd1});
        exp_q.push_back('{12'hB0F, 3'd2});
        bus.addreg = 4'b0001;
        bus.rd_sel = 3'd1;
        bus.rd_req = 1'b1;
        @(posedge clk); #1;
        bus.rd_sel = 3'd2;
        repeat (15) @(posedge clk);
        #1;
        chk("b2b_idle_after_e15", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_accept_e16", {28'd0, bus.busy, bus.reg_sel}, {28'd0, 1'b1, 3'd2});
        bus.rd_req = 1'b0;
        wait_idle("timeout_b2b");
        repeat (5) @(posedge clk);
        #1;

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        checks++;
        $display("FAIL global_timeout: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
